mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory port between the instruction-fetch requester
//  and the data (load/store) requester of the multicycle datapath. Each
//  requester issues req/ack_n transactions. The arbiter selects one, drives
//  the single memory bus (mreq/write/size/addr/wdata), then waits for the
//  memory's active-low ack and returns read data. It sits between
//  ctrl_datapath and the top-level memory pins.
// PARAMETERS
//  MAX_WAIT    15     cycles in ACCESS without memory ack before abort (1..255)
//  FETCH_SIZE  2'b00  size code driven on m_size for instruction fetches
// PORTS
//  clk       in   1   clock; all state changes on the rising edge
//  rst       in   1   synchronous, active-high reset
//  i_req     in   1   fetch request; hold high until i_ack_n is sampled low
//  i_addr    in   32  fetch address
//  i_rdata   out  32  fetched instruction; valid while i_ack_n=0
//  i_ack_n   out  1   fetch done; active-low, one-cycle pulse
//  d_req     in   1   data request; hold high until d_ack_n is sampled low
//  d_write   in   1   1=store, 0=load
//  d_size    in   2   access size code; passed through unchanged
//  d_addr    in   32  data address
//  d_wdata   in   32  store data
//  d_rdata   out  32  load data; valid while d_ack_n=0
//  d_ack_n   out  1   data done; active-low, one-cycle pulse
//  m_mreq    out  1   memory request, high for the whole access
//  m_write   out  1   memory write strobe; the top gates the DDT tristate with it
//  m_size    out  2   memory access size
//  m_addr    out  32  memory address
//  m_wdata   out  32  memory write data
//  m_rdata   in   32  memory read data; sampled in the cycle m_ack_n=0
//  m_ack_n   in   1   memory ack, active-low
//  bus_err   out  1   one-cycle pulse, aligned with the ack pulse of an aborted access
// BEHAVIOUR
//  - Reset (sync): state=IDLE; m_mreq=0, m_write=0, m_size=0, m_addr=0,
//    m_wdata=0; i_ack_n=1, d_ack_n=1; i_rdata=0, d_rdata=0; bus_err=0;
//    wait counter=0; last_grant=INSTR. Reset mid-access aborts it silently:
//    no ack pulse is issued, and m_mreq is low in the first cycle after the reset edge.
//  - All outputs are registered. The FSM has states IDLE, ACCESS and RESP.
//  - IDLE: sample i_req and d_req.
//    - Only one request high: grant that requester.
//    - Both high: grant the requester opposite last_grant. After reset,
//      data therefore wins the first tie.
//    - On grant: latch addr/size/write/wdata onto the m_* registers, set
//      m_mreq=1, record last_grant, clear the counter, go to ACCESS.
//    - Fetch grant: m_write=0, m_size=FETCH_SIZE, m_wdata unchanged.
//  - ACCESS, with m_ack_n=0: capture m_rdata into i_rdata or d_rdata of the
//    granted requester. Drive that requester's ack_n=0 next cycle, set m_mreq=0
//    and m_write=0, go to RESP.
//  - ACCESS, with m_ack_n=1: counter+1. When the counter reaches MAX_WAIT,
//    abort: m_mreq=0, m_write=0, ack_n=0, bus_err=1, rdata=32'h0, go to RESP.
//  - RESP: the ack_n pulse is low for exactly this cycle; bus_err clears.
//    Next state IDLE.
//  - m_ack_n is ignored outside ACCESS.
//  - Latency with a zero-wait memory: request sampled in cycle 0, m_mreq high
//    in cycle 1, ack in cycle 1, requester ack_n low in cycle 2. Next grant
//    can come no earlier than cycle 3, so the bus is free every 3rd cycle.
//  - Requester contract: drop req on the edge at which ack_n is sampled low.
//    A req still high in the cycle after the ack pulse is a new request.
//  - Dropping req mid-access is illegal. The access still completes and the
//    ack pulse is still issued.
//  - m_addr, m_size and m_wdata hold their values while m_mreq=0; only m_mreq
//    qualifies them.
//  - The counter saturates and never wraps. It is 8 bits wide; MAX_WAIT=1
//    aborts after one unacked cycle.
//  - Never: both ack_n low at once; m_mreq high in RESP or IDLE.
// TESTING
//  1 Fetch only: i_req=1, i_addr=0x100, m_ack_n low 1 cycle after m_mreq
//    with m_rdata=0xDEADBEEF -> m_addr=0x100, m_write=0, m_size=FETCH_SIZE;
//    i_ack_n low 1 cycle with i_rdata=0xDEADBEEF; d_ack_n stays 1.
//  2 Store: d_req=1, d_write=1, d_addr=0x2000, d_wdata=0x12345678, d_size=2'b01,
//    memory 2 wait states -> m_mreq high 3 cycles with m_write=1 and
//    m_wdata=0x12345678; d_ack_n pulse 1 cycle after the ack.
//  3 Tie after reset, then held requests: both req high -> data granted first,
//    then fetch, then data (alternates); no double grant, never both acks low.
//  4 Timeout: MAX_WAIT=15, m_ack_n held 1 -> m_mreq drops after 15 ACCESS
//    cycles; d_ack_n=0, bus_err=1 and d_rdata=0 in the same cycle; next request served.
//  5 Reset mid-access: rst=1 on the 2nd ACCESS cycle -> m_mreq=0 and both
//    ack_n=1 next cycle; a late m_ack_n=0 is ignored; the first tie after reset goes to data.
//  6 Back-to-back loads with d_req held through the ack -> exactly one new
//    access per 3 cycles with zero-wait memory; d_rdata updates only on acks.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between the fetch and
// data requesters; registered outputs, IDLE/ACCESS/RESP FSM with timeout.
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT   = 15,
  parameter logic [1:0]  FETCH_SIZE = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack_n,
  output logic        m_mreq,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic       GNT_I    = 1'b0;
  localparam logic       GNT_D    = 1'b1;
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t      state;
  state_t      state_nxt;

  // last_grant doubles as the owner of the access in flight
  logic        last_grant;
  logic        grant_nxt;
  logic        pick_data;

  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [7:0]  cnt_inc;
  logic        timeout;

  logic        mreq_nxt;
  logic        write_nxt;
  logic [1:0]  size_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] irdata_nxt;
  logic [31:0] drdata_nxt;
  logic        iack_nxt;
  logic        dack_nxt;
  logic        err_nxt;

  // pick the requester: a lone request wins, a tie goes opposite last_grant
  always_comb begin
    pick_data = 1'b0;
    unique case (1'b1)
      (d_req && i_req):  pick_data = (last_grant == GNT_I);
      (d_req && !i_req): pick_data = 1'b1;
      default:           pick_data = 1'b0;
    endcase
  end

  // saturating wait counter and abort condition
  always_comb begin
    cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    timeout = (cnt_inc >= WAIT_LIM);
  end

  // state register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      cnt        <= 8'd0;
      m_mreq     <= 1'b0;
      m_write    <= 1'b0;
      m_size     <= 2'b00;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      i_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
      i_ack_n    <= 1'b1;
      d_ack_n    <= 1'b1;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
      cnt        <= cnt_nxt;
      m_mreq     <= mreq_nxt;
      m_write    <= write_nxt;
      m_size     <= size_nxt;
      m_addr     <= addr_nxt;
      m_wdata    <= wdata_nxt;
      i_rdata    <= irdata_nxt;
      d_rdata    <= drdata_nxt;
      i_ack_n    <= iack_nxt;
      d_ack_n    <= dack_nxt;
      bus_err    <= err_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!m_ack_n || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    mreq_nxt   = m_mreq;
    write_nxt  = m_write;
    size_nxt   = m_size;
    addr_nxt   = m_addr;
    wdata_nxt  = m_wdata;
    irdata_nxt = i_rdata;
    drdata_nxt = d_rdata;
    iack_nxt   = 1'b1;
    dack_nxt   = 1'b1;
    err_nxt    = 1'b0;
    cnt_nxt    = cnt;
    grant_nxt  = last_grant;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          mreq_nxt  = 1'b1;
          grant_nxt = pick_data ? GNT_D : GNT_I;
          cnt_nxt   = 8'd0;
          if (pick_data) begin
            write_nxt = d_write;
            size_nxt  = d_size;
            addr_nxt  = d_addr;
            wdata_nxt = d_wdata;
          end else begin
            write_nxt = 1'b0;
            size_nxt  = FETCH_SIZE;
            addr_nxt  = i_addr;
          end
        end
      end
      ACCESS: begin
        if (!m_ack_n) begin
          mreq_nxt  = 1'b0;
          write_nxt = 1'b0;
          if (last_grant == GNT_D) begin
            drdata_nxt = m_rdata;
            dack_nxt   = 1'b0;
          end else begin
            irdata_nxt = m_rdata;
            iack_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = cnt_inc;
          if (timeout) begin
            mreq_nxt  = 1'b0;
            write_nxt = 1'b0;
            err_nxt   = 1'b1;
            if (last_grant == GNT_D) begin
              drdata_nxt = 32'h0;
              dack_nxt   = 1'b0;
            end else begin
              irdata_nxt = 32'h0;
              iack_nxt   = 1'b0;
            end
          end
        end
      end
      RESP: begin
        cnt_nxt = cnt;
      end
      default: begin
        cnt_nxt = cnt;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with per-requester expectation
// queues; a monitor pairs every ack pulse with the access that produced it.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack_n;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack_n;
  logic        m_mreq;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ack_n;
  logic        bus_err;

  mem_bus_arbiter #(.MAX_WAIT(15), .FETCH_SIZE(2'b00)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_mreq(m_mreq), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          len;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];
  bit   order_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // memory model: ack after mem_wait wait states, or never when hung
  logic mem_ack   = 1'b1;
  logic force_low = 1'b0;
  bit   mem_hang  = 1'b0;
  int   mem_wait  = 0;
  int   acc_cnt   = 0;

  assign m_ack_n = mem_ack & ~force_low;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'hDEAD_BEEF;
      32'h0000_0104: mem_rd = 32'h0000_0013;
      32'h0000_0200: mem_rd = 32'h0010_0093;
      32'h0000_0208: mem_rd = 32'h0020_0113;
      32'h0000_2000: mem_rd = 32'h0BAD_F00D;
      32'h0000_4000: mem_rd = 32'h1111_1111;
      32'h0000_4004: mem_rd = 32'h2222_2222;
      32'h0000_4008: mem_rd = 32'h3333_3333;
      32'h0000_400C: mem_rd = 32'h4444_4444;
      32'h0000_5000: mem_rd = 32'hCAFE_0001;
      32'h0000_5004: mem_rd = 32'hCAFE_0002;
      32'h0000_5008: mem_rd = 32'hCAFE_0003;
      default:       mem_rd = 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_mreq === 1'b1) begin
      mem_ack <= !((acc_cnt == mem_wait) && !mem_hang);
      m_rdata <= mem_rd(m_addr);
      acc_cnt <= acc_cnt + 1;
    end else begin
      mem_ack <= 1'b1;
      acc_cnt <= 0;
    end
  end

  // monitor
  logic        prev_mreq    = 1'b0;
  logic [31:0] prev_i_rdata = 32'h0;
  logic [31:0] prev_d_rdata = 32'h0;
  logic        cap_write;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  int          run         = 0;
  int          cyc         = 0;
  int          last_rise   = -100;
  int          spacing_exp = 0;
  bit          mon_quiet   = 1'b1;
  exp_t        e;
  bit          who_d;
  bit          have;
  bit          inv_ok;
  string       pfx;

  always @(negedge clk) begin
    if (!mon_quiet) begin
      if (m_mreq && !prev_mreq) begin
        cap_write = m_write;
        cap_size  = m_size;
        cap_addr  = m_addr;
        cap_wdata = m_wdata;
        run       = 1;
        if (spacing_exp != 0)
          chk("grant_spacing", 32'(cyc - last_rise), 32'(spacing_exp));
        last_rise = cyc;
      end else if (m_mreq) begin
        run++;
      end
      if (!i_ack_n || !d_ack_n) begin
        who_d = !d_ack_n;
        pfx   = who_d ? "d_" : "i_";
        have  = who_d ? (q_d.size() != 0) : (q_i.size() != 0);
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL %sunexpected_ack: got ack with no request pending at %0t",
                   pfx, $time);
        end else begin
          if (who_d) e = q_d.pop_front();
          else       e = q_i.pop_front();
          chk({pfx, "addr"}, cap_addr, e.addr);
          chk({pfx, "write"}, 32'(cap_write), 32'(e.write));
          chk({pfx, "size"}, 32'(cap_size), 32'(e.size));
          if (e.write) chk({pfx, "wdata"}, cap_wdata, e.wdata);
          chk({pfx, "rdata"}, who_d ? d_rdata : i_rdata, e.rdata);
          chk({pfx, "bus_err"}, 32'(bus_err), 32'(e.err));
          chk({pfx, "mreq_len"}, 32'(run), 32'(e.len));
          chk({pfx, "ack_timing"}, {30'b0, prev_mreq, m_mreq}, 32'd2);
        end
        if (order_q.size() != 0)
          chk("grant_order", 32'(who_d), 32'(order_q.pop_front()));
      end
      inv_ok = !(!i_ack_n && !d_ack_n)
            && (!bus_err || !i_ack_n || !d_ack_n)
            && (!d_ack_n || d_rdata == prev_d_rdata)
            && (!i_ack_n || i_rdata == prev_i_rdata)
            && !(m_mreq && (!i_ack_n || !d_ack_n));
      chk("invariants", 32'(inv_ok), 32'd1);
    end
    prev_mreq    = m_mreq;
    prev_i_rdata = i_rdata;
    prev_d_rdata = d_rdata;
    cyc++;
  end

  task automatic wait_ack(input bit d);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((d ? d_ack_n : i_ack_n) == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no %s ack within 200 cycles, required one",
               d ? "d" : "i");
    end
  endtask

  task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rdata,
                           input logic err, input int len);
    exp_t x;
    x.write = 1'b0; x.size = 2'b00; x.addr = addr; x.wdata = 32'h0;
    x.rdata = rdata; x.err = err; x.len = len;
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = addr;
    q_i.push_back(x);
    wait_ack(1'b0);
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  task automatic data_txn(input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic err,
                          input int len, input bit hold);
    exp_t x;
    x.write = wr; x.size = size; x.addr = addr; x.wdata = wdata;
    x.rdata = rdata; x.err = err; x.len = len;
    @(negedge clk);
    d_req   = 1'b1;
    d_write = wr;
    d_size  = size;
    d_addr  = addr;
    d_wdata = wdata;
    q_d.push_back(x);
    wait_ack(1'b1);
    if (!hold) begin
      @(posedge clk);
      #1 d_req = 1'b0;
    end
  endtask

  task automatic idle_reset();
    mon_quiet = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 mon_quiet = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required end of run");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_write = 1'b0; d_size = 2'b00;
    d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_mreq", 32'(m_mreq), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_size", 32'(m_size), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_i_ack_n", 32'(i_ack_n), 32'd1);
    chk("rst_d_ack_n", 32'(d_ack_n), 32'd1);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1 mon_quiet = 1'b0;

    // fetch only, zero-wait memory
    mem_wait = 0;
    fetch_txn(32'h100, 32'hDEAD_BEEF, 1'b0, 1);

    // store with two wait states
    mem_wait = 2;
    data_txn(1'b1, 2'b01, 32'h2000, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 3, 1'b0);

    // tie after reset, data held: data, fetch, data
    idle_reset();
    mem_wait = 0;
    order_q.push_back(1'b1);
    order_q.push_back(1'b0);
    order_q.push_back(1'b1);
    fork
      begin
        data_txn(1'b0, 2'b10, 32'h5000, 32'h0, 32'hCAFE_0001, 1'b0, 1, 1'b1);
        data_txn(1'b0, 2'b10, 32'h5004, 32'h0, 32'hCAFE_0002, 1'b0, 1, 1'b0);
      end
      fetch_txn(32'h200, 32'h0010_0093, 1'b0, 1);
    join

    // timeout: memory never acks, then a normal fetch
    mem_hang = 1'b1;
    data_txn(1'b0, 2'b10, 32'h3000, 32'h0, 32'h0, 1'b1, 15, 1'b0);
    mem_hang = 1'b0;
    fetch_txn(32'h104, 32'h0000_0013, 1'b0, 1);

    // reset on the second ACCESS cycle
    mem_hang = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h6000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_mreq) break;
    end
    chk("abort_mreq_rose", 32'(m_mreq), 32'd1);
    @(negedge clk);
    mon_quiet = 1'b1;
    rst = 1'b1;
    d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_m_mreq", 32'(m_mreq), 32'd0);
    chk("abort_m_write", 32'(m_write), 32'd0);
    chk("abort_acks", {30'b0, i_ack_n, d_ack_n}, 32'd3);
    chk("abort_bus_err", 32'(bus_err), 32'd0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    force_low = 1'b1;
    mem_hang = 1'b0;
    @(posedge clk);
    #1 force_low = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_ack_ignored", {29'b0, i_ack_n, d_ack_n, m_mreq}, 32'd6);
    end
    @(posedge clk);
    #1 mon_quiet = 1'b0;
    order_q.push_back(1'b1);
    order_q.push_back(1'b0);
    fork
      data_txn(1'b0, 2'b10, 32'h5008, 32'h0, 32'hCAFE_0003, 1'b0, 1, 1'b0);
      fetch_txn(32'h208, 32'h0020_0113, 1'b0, 1);
    join

    // back-to-back loads with d_req held through each ack
    mem_wait = 0;
    data_txn(1'b0, 2'b10, 32'h4000, 32'h0, 32'h1111_1111, 1'b0, 1, 1'b1);
    spacing_exp = 3;
    data_txn(1'b0, 2'b10, 32'h4004, 32'h0, 32'h2222_2222, 1'b0, 1, 1'b1);
    data_txn(1'b0, 2'b10, 32'h4008, 32'h0, 32'h3333_3333, 1'b0, 1, 1'b1);
    data_txn(1'b0, 2'b10, 32'h400C, 32'h0, 32'h4444_4444, 1'b0, 1, 1'b0);
    spacing_exp = 0;

    repeat (5) @(negedge clk);
    chk("left_i", 32'(q_i.size()), 32'd0);
    chk("left_d", 32'(q_d.size()), 32'd0);
    chk("left_order", 32'(order_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
